fmap_pool_buffer: RTL and testbench

// - Banked feature-map buffer between conv output and next-layer input: one bank per output channel.
// - Stores sat(value+bias) per pixel; reads two pixels from every bank in parallel.
// - Pools each bank 2x2 in place, compacting results to the bank's low addresses.
// - Generalises the fixed 8-bit/8-channel/28x28 max-pool buffer.

---
 rtl/fmap_pool_buffer.sv | 247 ++++++++++++++++++++++++
 tb/tb_fmap_pool_buffer.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/fmap_pool_buffer.sv
// Banked feature-map buffer: saturating bias-add writes, dual-port parallel reads, in-place 2x2 pooling per bank.
// Build option: define POOL_AVG_EN for average pooling; max pooling otherwise.
module fmap_pool_buffer #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16,
  parameter int NUM_CH = 8,
  parameter int W      = 28,
  parameter int H      = 28,
  parameter int ADDR_W = 10,
  parameter int RELU   = 0,
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         store,
  input  logic [CH_W-1:0]              wr_ch,
  input  logic [ADDR_W-1:0]            wr_addr,
  input  logic signed [ACC_W-1:0]      value,
  input  logic signed [DATA_W-1:0]     bias,
  input  logic                         load,
  input  logic [ADDR_W-1:0]            rd_addr0,
  input  logic [ADDR_W-1:0]            rd_addr1,
  output logic [NUM_CH*2*DATA_W-1:0]   rd_data,
  input  logic                         pool_start,
  output logic                         pool_busy,
  output logic                         pool_done
);

  // state    | meaning
  // S_IDLE   | host store/load serviced, waiting for pool_start
  // S_RD_TOP | read top pixel pair of current window
  // S_RD_BOT | read bottom pixel pair of current window
  // S_WR     | write pooled result, advance window
  // S_DONE   | one-cycle completion pulse

  localparam int WO    = W / 2;
  localparam int HO    = H / 2;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CC_W  = $clog2(WO + 1);
  localparam int RC_W  = $clog2(HO + 1);

  localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((2 ** (DATA_W-1)) - 1);
  localparam logic signed [ACC_W:0] SAT_MIN = (ACC_W+1)'(-(2 ** (DATA_W-1)));

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_TOP,
    S_RD_BOT,
    S_WR,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [CC_W-1:0] col_q;
  logic [RC_W-1:0] row_q;
  logic [CH_W-1:0] ch_q;
  logic            last_win;

  logic signed [DATA_W-1:0] top0_q, top1_q, bot0_q, bot1_q;
  logic signed [DATA_W-1:0] pool_res;

  logic signed [ACC_W:0]    sum;
  logic signed [DATA_W-1:0] wr_pix;

  logic                     store_ok, load_ok;
  logic [ADDR_W-1:0]        pool_rd0, pool_rd1, pool_wr;
  logic [ADDR_W-1:0]        raddr0, raddr1, waddr;
  logic [DATA_W-1:0]        wdata;
  logic [DATA_W-1:0]        bank_rd0 [NUM_CH];
  logic [DATA_W-1:0]        bank_rd1 [NUM_CH];
  logic [DATA_W-1:0]        sel_rd0, sel_rd1;

  assign store_ok = store && (state_q == S_IDLE);
  assign load_ok  = load  && (state_q == S_IDLE);

  // Sum is one bit wider than the accumulator so value+bias never wraps before saturation.
  always_comb begin
    sum = {value[ACC_W-1], value} + {{(ACC_W+1-DATA_W){bias[DATA_W-1]}}, bias};
    if (sum > SAT_MAX)
      wr_pix = SAT_MAX[DATA_W-1:0];
    else if (sum < SAT_MIN)
      wr_pix = SAT_MIN[DATA_W-1:0];
    else
      wr_pix = sum[DATA_W-1:0];
    if (RELU != 0 && wr_pix[DATA_W-1])
      wr_pix = '0;
  end

`ifdef POOL_AVG_EN
  logic signed [DATA_W+1:0] avg_sum;
  logic signed [DATA_W+1:0] avg_shr;

  always_comb begin
    avg_sum = {{2{top0_q[DATA_W-1]}}, top0_q} + {{2{top1_q[DATA_W-1]}}, top1_q}
            + {{2{bot0_q[DATA_W-1]}}, bot0_q} + {{2{bot1_q[DATA_W-1]}}, bot1_q};
    avg_shr  = avg_sum >>> 2;
    pool_res = avg_shr[DATA_W-1:0];
    if (RELU != 0 && pool_res[DATA_W-1])
      pool_res = '0;
  end
`else
  logic signed [DATA_W-1:0] max_top, max_bot;

  always_comb begin
    max_top  = (top0_q > top1_q) ? top0_q : top1_q;
    max_bot  = (bot0_q > bot1_q) ? bot0_q : bot1_q;
    pool_res = (max_top > max_bot) ? max_top : max_bot;
    if (RELU != 0 && pool_res[DATA_W-1])
      pool_res = '0;
  end
`endif

  always_comb begin
    pool_rd0 = ADDR_W'((2 * int'(row_q) + ((state_q == S_RD_BOT) ? 1 : 0)) * W + 2 * int'(col_q));
    pool_rd1 = pool_rd0 + ADDR_W'(1);
    pool_wr  = ADDR_W'(int'(row_q) * WO + int'(col_q));
  end

  assign raddr0 = (state_q == S_IDLE) ? rd_addr0 : pool_rd0;
  assign raddr1 = (state_q == S_IDLE) ? rd_addr1 : pool_rd1;
  assign waddr  = (state_q == S_WR) ? pool_wr : wr_addr;
  assign wdata  = (state_q == S_WR) ? pool_res : wr_pix;

  // Out-of-range wr_ch matches no bank, so the write is simply dropped.
  for (genvar g = 0; g < NUM_CH; g++) begin : g_bank
    logic [DATA_W-1:0] mem [DEPTH];
    logic              we;

    assign we = (store_ok && (wr_ch == CH_W'(g))) ||
                ((state_q == S_WR) && (ch_q == CH_W'(g)));

    always_ff @(posedge clk) begin
      if (we)
        mem[waddr] <= wdata;
    end

    assign bank_rd0[g] = mem[raddr0];
    assign bank_rd1[g] = mem[raddr1];
  end

  always_comb begin
    sel_rd0 = '0;
    sel_rd1 = '0;
    for (int g = 0; g < NUM_CH; g++) begin
      if (ch_q == CH_W'(g)) begin
        sel_rd0 = bank_rd0[g];
        sel_rd1 = bank_rd1[g];
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data <= '0;
    end else if (load_ok) begin
      for (int g = 0; g < NUM_CH; g++) begin
        rd_data[(2*g)*DATA_W   +: DATA_W] <= bank_rd0[g];
        rd_data[(2*g+1)*DATA_W +: DATA_W] <= bank_rd1[g];
      end
    end
  end

  assign last_win = (col_q == CC_W'(WO - 1)) && (row_q == RC_W'(HO - 1)) &&
                    (ch_q == CH_W'(NUM_CH - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col_q  <= '0;
      row_q  <= '0;
      ch_q   <= '0;
      top0_q <= '0;
      top1_q <= '0;
      bot0_q <= '0;
      bot1_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pool_start) begin
            col_q <= '0;
            row_q <= '0;
            ch_q  <= '0;
          end
        end
        S_RD_TOP: begin
          top0_q <= sel_rd0;
          top1_q <= sel_rd1;
        end
        S_RD_BOT: begin
          bot0_q <= sel_rd0;
          bot1_q <= sel_rd1;
        end
        S_WR: begin
          if (col_q == CC_W'(WO - 1)) begin
            col_q <= '0;
            if (row_q == RC_W'(HO - 1)) begin
              row_q <= '0;
              ch_q  <= ch_q + 1'b1;
            end else begin
              row_q <= row_q + 1'b1;
            end
          end else begin
            col_q <= col_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d   = state_q;
    pool_busy = 1'b0;
    pool_done = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pool_start)
          state_d = S_RD_TOP;
      end
      S_RD_TOP: begin
        pool_busy = 1'b1;
        state_d   = S_RD_BOT;
      end
      S_RD_BOT: begin
        pool_busy = 1'b1;
        state_d   = S_WR;
      end
      S_WR: begin
        pool_busy = 1'b1;
        state_d   = last_win ? S_DONE : S_RD_TOP;
      end
      S_DONE: begin
        pool_done = 1'b1;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_fmap_pool_buffer.sv
// Directed bench for fmap_pool_buffer: write saturation table, read-during-write, pooling on small maps, busy lockout, mid-pool reset.
module tb_fmap_pool_buffer;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               store = 1'b0;
  logic               load = 1'b0;
  logic               pstart_p = 1'b0;
  logic               pstart_o = 1'b0;
  logic [2:0]         wr_ch = '0;
  logic [9:0]         wr_addr = '0;
  logic [9:0]         rd_addr0 = '0;
  logic [9:0]         rd_addr1 = '0;
  logic signed [15:0] value = '0;
  logic signed [7:0]  bias = '0;

  logic [127:0] rd_a;
  logic [31:0]  rd_r, rd_p;
  logic [15:0]  rd_o;
  logic busy_a, done_a, busy_r, done_r, busy_p, done_p, busy_o, done_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  fmap_pool_buffer #(.NUM_CH(8)) u_a (
    .clk(clk), .rst(rst), .store(store), .wr_ch(wr_ch), .wr_addr(wr_addr),
    .value(value), .bias(bias), .load(load), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data(rd_a), .pool_start(1'b0), .pool_busy(busy_a), .pool_done(done_a));

  fmap_pool_buffer #(.NUM_CH(2), .W(4), .H(4), .RELU(1)) u_r (
    .clk(clk), .rst(rst), .store(store), .wr_ch(wr_ch[0:0]), .wr_addr(wr_addr),
    .value(value), .bias(bias), .load(load), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data(rd_r), .pool_start(1'b0), .pool_busy(busy_r), .pool_done(done_r));

  fmap_pool_buffer #(.NUM_CH(2), .W(4), .H(4)) u_p (
    .clk(clk), .rst(rst), .store(store), .wr_ch(wr_ch[0:0]), .wr_addr(wr_addr),
    .value(value), .bias(bias), .load(load), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data(rd_p), .pool_start(pstart_p), .pool_busy(busy_p), .pool_done(done_p));

  fmap_pool_buffer #(.NUM_CH(1), .W(5), .H(3)) u_o (
    .clk(clk), .rst(rst), .store(store), .wr_ch(wr_ch[0:0]), .wr_addr(wr_addr),
    .value(value), .bias(bias), .load(load), .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
    .rd_data(rd_o), .pool_start(pstart_o), .pool_busy(busy_o), .pool_done(done_o));

  typedef struct {
    int ch;
    int addr;
    int val;
    int bs;
    int exp;
    int exp_relu;
  } vec_t;

  vec_t vecs[10];

  function automatic int px(input logic [127:0] bus, input int idx);
    return int'($signed(bus[idx*8 +: 8]));
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic do_store(input int ch, input int addr, input int v, input int b);
    store   = 1'b1;
    wr_ch   = 3'(ch);
    wr_addr = 10'(addr);
    value   = 16'(v);
    bias    = 8'(b);
    @(negedge clk);
    store   = 1'b0;
  endtask

  task automatic do_load(input int a0, input int a1);
    load     = 1'b1;
    rd_addr0 = 10'(a0);
    rd_addr1 = 10'(a1);
    @(negedge clk);
    load     = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_p, t_o, dc_p, dc_o, t2;
    int e_p00, e_p01, e_p10, e_p11, e_p20, e_p21, e_p30, e_p31, e_o0, e_o1;

    vecs[0] = '{3, 5,    120,   20,  127,  127};
    vecs[1] = '{1, 7,   -100,  -50, -128,    0};
    vecs[2] = '{0, 9,      3,   -1,    2,    2};
    vecs[3] = '{2, 11,  -200,    0, -128,    0};
    vecs[4] = '{5, 12, 32767,  127,  127,  127};
    vecs[5] = '{4, 13, -32768, -128, -128,   0};
    vecs[6] = '{6, 14,    -5,    0,   -5,    0};
    vecs[7] = '{7, 15,   127,    0,  127,  127};
    vecs[8] = '{0, 16,  -128,    0, -128,    0};
    vecs[9] = '{3, 17,     0, -128, -128,    0};

`ifdef POOL_AVG_EN
    e_p00 = 2;  e_p01 = 4;  e_p10 = -3;  e_p11 = -5;
    e_p20 = 10; e_p21 = 12; e_p30 = -11; e_p31 = -13;
    e_o0  = 3;  e_o1  = 5;
`else
    e_p00 = 5;  e_p01 = 7;  e_p10 = 0;   e_p11 = -2;
    e_p20 = 13; e_p21 = 15; e_p30 = -8;  e_p31 = -10;
    e_o0  = 6;  e_o1  = 8;
`endif

    repeat (3) @(negedge clk);
    check("reset rd_a", int'(rd_a != '0), 0);
    check("reset rd_p", int'(rd_p != '0), 0);
    check("reset rd_o", int'(rd_o != '0), 0);
    check("reset flags", int'({busy_a, done_a, busy_r, done_r, busy_p, done_p, busy_o, done_o}), 0);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 10; i++) begin
      do_store(vecs[i].ch, vecs[i].addr, vecs[i].val, vecs[i].bs);
      do_load(vecs[i].addr, vecs[i].addr);
      check($sformatf("sat p0 v%0d", i), px(rd_a, vecs[i].ch*2), vecs[i].exp);
      check($sformatf("sat p1 v%0d", i), px(rd_a, vecs[i].ch*2+1), vecs[i].exp);
      check($sformatf("relu v%0d", i), px({96'd0, rd_r}, (vecs[i].ch%2)*2), vecs[i].exp_relu);
    end

    // read-during-write to the same address returns the old contents
    load = 1'b1; rd_addr0 = 10'd5; rd_addr1 = 10'd5;
    do_store(3, 5, 0, 0);
    load = 1'b0;
    check("rdw old", px(rd_a, 6), 127);
    do_load(5, 5);
    check("rdw new", px(rd_a, 6), 0);

    for (int i = 0; i < 16; i++) begin
      do_store(0, i, i, 0);
      do_store(1, i, -i, 0);
    end
    do_store(0, 20, 9, 0);
    do_load(0, 1);
    check("pre ch1p1", px({96'd0, rd_p}, 3), -1);

    // pool_start together with store and load: both serviced first
    pstart_p = 1'b1; pstart_o = 1'b1;
    store = 1'b1; wr_ch = 3'd0; wr_addr = 10'd21; value = 16'sd33; bias = 8'sd0;
    load = 1'b1; rd_addr0 = 10'd2; rd_addr1 = 10'd3;
    @(negedge clk);
    pstart_p = 1'b0; pstart_o = 1'b0; store = 1'b0; load = 1'b0;
    check("start busy_p", int'(busy_p), 1);
    check("start busy_o", int'(busy_o), 1);
    check("start load p0", px({96'd0, rd_p}, 0), 2);
    check("start load ch1p1", px({96'd0, rd_p}, 3), -3);

    t_p = -1; t_o = -1; dc_p = 0; dc_o = 0;
    for (int n = 1; n <= 40; n++) begin
      if (n == 2) begin
        store = 1'b1; wr_ch = 3'd0; wr_addr = 10'd20; value = 16'sd55;
        load = 1'b1; rd_addr0 = 10'd15; rd_addr1 = 10'd15;
      end else begin
        store = 1'b0; load = 1'b0;
      end
      @(negedge clk);
      if (n == 5) check("busy hold rd_p", px({96'd0, rd_p}, 0), 2);
      if (done_p) begin
        if (t_p < 0) t_p = n;
        dc_p++;
        check("done_p busy_p", int'(busy_p), 0);
      end
      if (done_o) begin
        if (t_o < 0) t_o = n;
        dc_o++;
      end
    end
    check("pool_p cycles", t_p, 24);
    check("pool_p pulses", dc_p, 1);
    check("pool_o cycles", t_o, 6);
    check("pool_o pulses", dc_o, 1);

    do_load(0, 1);
    check("p ch0 a0", px({96'd0, rd_p}, 0), e_p00);
    check("p ch0 a1", px({96'd0, rd_p}, 1), e_p01);
    check("p ch1 a0", px({96'd0, rd_p}, 2), e_p10);
    check("p ch1 a1", px({96'd0, rd_p}, 3), e_p11);
    check("o a0", px({112'd0, rd_o}, 0), e_o0);
    check("o a1", px({112'd0, rd_o}, 1), e_o1);
    do_load(2, 3);
    check("p ch0 a2", px({96'd0, rd_p}, 0), e_p20);
    check("p ch0 a3", px({96'd0, rd_p}, 1), e_p21);
    check("p ch1 a2", px({96'd0, rd_p}, 2), e_p30);
    check("p ch1 a3", px({96'd0, rd_p}, 3), e_p31);
    check("o a2 kept", px({112'd0, rd_o}, 0), 2);
    check("o a3 kept", px({112'd0, rd_o}, 1), 3);
    do_load(4, 20);
    check("o a4 drop ch1", px({112'd0, rd_o}, 0), 4);
    check("p busy store ignored", px({96'd0, rd_p}, 1), 9);
    do_load(21, 21);
    check("p start store", px({96'd0, rd_p}, 0), 33);

    // reset during a pool clears flags at once, then a fresh pool completes
    pstart_p = 1'b1;
    @(negedge clk);
    pstart_p = 1'b0;
    repeat (9) @(negedge clk);
    check("mid busy before rst", int'(busy_p), 1);
    #2 rst = 1'b0;
    #1;
    check("mid rst busy", int'(busy_p), 0);
    check("mid rst done", int'(done_p), 0);
    check("mid rst rd_p", int'(rd_p != '0), 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    pstart_p = 1'b1;
    @(negedge clk);
    pstart_p = 1'b0;
    t2 = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done_p && t2 < 0) t2 = n;
    end
    check("repool cycles", t2, 24);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
